// File: rtl/md_iter_unit.sv
// rtl/md_iter_unit.sv - iterative MULT/DIV/MADD/MSUB unit, one shift-add or restoring step per cycle
// Optional MD_EARLY_OUT_EN: trivially-resolved operands bypass the iteration phase.
module md_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 opn_valid,
    output logic                 opn_ready,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   hilo_in,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);
    localparam int W2 = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          op_q;
    logic [W2-1:0]       hilo_q;
    logic [WIDTH-1:0]    ma_q;
    logic [WIDTH-1:0]    mb_q;
    logic [W2-1:0]       acc_q;
    logic                a_neg_q;
    logic                b_neg_q;
    logic                b_zero_q;
    logic [W2-1:0]       result_q;
    logic                res_valid_q;

    logic                in_div;
    logic                in_signed;
    logic                a_neg_in;
    logic                b_neg_in;
    logic [WIDTH-1:0]    abs_a;
    logic [WIDTH-1:0]    abs_b;

    assign in_div    = ~op[2] & op[1];
    assign in_signed = ~op[0];
    assign a_neg_in  = in_signed & a[WIDTH-1];
    assign b_neg_in  = in_signed & b[WIDTH-1];
    assign abs_a     = a_neg_in ? ({WIDTH{1'b0}} - a) : a;
    assign abs_b     = b_neg_in ? ({WIDTH{1'b0}} - b) : b;

    // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
    logic                div_q;
    logic [WIDTH:0]      mul_sum;
    logic [WIDTH:0]      rem_sh;
    logic [WIDTH:0]      trial;
    logic [W2-1:0]       acc_d;

    assign div_q   = ~op_q[2] & op_q[1];
    assign mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (acc_q[0] ? ma_q : {WIDTH{1'b0}})};
    assign rem_sh  = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
    assign trial   = rem_sh - {1'b0, mb_q};

    always_comb begin
        acc_d = acc_q;
        if (div_q) begin
            if (!trial[WIDTH])
                acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else
                acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
    end

    // Sign correction and accumulation applied once the magnitude result is complete.
    logic [WIDTH-1:0]    quo;
    logic [WIDTH-1:0]    rem;
    logic [WIDTH-1:0]    a_raw;
    logic [W2-1:0]       prod;
    logic [W2-1:0]       fix_d;

    assign quo   = acc_q[WIDTH-1:0];
    assign rem   = acc_q[W2-1:WIDTH];
    assign a_raw = a_neg_q ? ({WIDTH{1'b0}} - ma_q) : ma_q;
    assign prod  = (a_neg_q ^ b_neg_q) ? ({W2{1'b0}} - acc_q) : acc_q;

    always_comb begin
        fix_d = prod;
        if (div_q) begin
            if (b_zero_q)
                fix_d = {a_raw, {WIDTH{1'b1}}};
            else
                fix_d = {(a_neg_q ? ({WIDTH{1'b0}} - rem) : rem),
                         ((a_neg_q ^ b_neg_q) ? ({WIDTH{1'b0}} - quo) : quo)};
        end else if (op_q[2]) begin
            fix_d = op_q[1] ? (hilo_q - prod) : (hilo_q + prod);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            hilo_q      <= '0;
            ma_q        <= '0;
            mb_q        <= '0;
            acc_q       <= '0;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            b_zero_q    <= 1'b0;
            result_q    <= '0;
            res_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (opn_valid) begin
                        op_q     <= op;
                        hilo_q   <= hilo_in;
                        ma_q     <= abs_a;
                        mb_q     <= abs_b;
                        a_neg_q  <= a_neg_in;
                        b_neg_q  <= b_neg_in;
                        b_zero_q <= (b == {WIDTH{1'b0}});
                        acc_q    <= {{WIDTH{1'b0}}, (in_div ? abs_a : abs_b)};
                        cnt_q    <= CNT_W'(WIDTH);
                        state_q  <= S_BUSY;
`ifdef MD_EARLY_OUT_EN
                        if (in_div && (abs_a < abs_b)) begin
                            acc_q   <= {abs_a, {WIDTH{1'b0}}};
                            cnt_q   <= '0;
                            state_q <= S_FIX;
                        end else if (!in_div && (a == {WIDTH{1'b0}} || b == {WIDTH{1'b0}})) begin
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= S_FIX;
                        end
`endif
                    end
                end
                S_BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1))
                        state_q <= S_FIX;
                end
                S_FIX: begin
                    result_q    <= fix_d;
                    res_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign opn_ready = (state_q == S_IDLE);
    assign res_valid = res_valid_q;
    assign result    = result_q;
    assign busy      = (state_q != S_IDLE) && !((state_q == S_DONE) && res_ready);

endmodule
